// File: rtl/txcrc_sched.sv
// Transmit scheduler feeding a byte-wide CRC appender: pads short frames,
// reserves the CRC flush window, enforces the inter-packet gap and aborts on underrun.
module txcrc_sched #(
  parameter int MIN_LEN   = 60,
  parameter int CRC_BYTES = 4,
  parameter int IPG_BYTES = 12,
  parameter int LGLEN     = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_cfg_crc,
  input  logic       i_cfg_pad,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_crc_v,
  output logic [7:0] o_crc_d,
  output logic       o_crc_en,
  output logic       o_busy,
  output logic       o_underrun
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FLUSH, DRAIN, IPG} state_t;

  localparam logic [LGLEN-1:0] MIN_L    = LGLEN'(MIN_LEN);
  localparam logic [7:0]       CRC_LAST = 8'(CRC_BYTES - 1);
  localparam logic [7:0]       IPG_LAST = 8'(IPG_BYTES - 1);

  state_t           state_q;
  logic [LGLEN-1:0] cnt_q;
  logic [7:0]       gap_q;
  logic             crc_q;
  logic             pad_q;
  logic             crc_v_q;
  logic [7:0]       crc_d_q;
  logic             crc_en_q;
  logic             underrun_q;

  function automatic logic [LGLEN-1:0] sat_inc(input logic [LGLEN-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // With CRC disabled there is nothing to flush, so the gap starts immediately.
  function automatic state_t after_payload(input logic crc);
    return (crc && CRC_BYTES > 0) ? FLUSH : IPG;
  endfunction

  function automatic state_t after_last(input logic pad, input logic crc,
                                        input logic [LGLEN-1:0] n);
    return (pad && n < MIN_L) ? PAD : after_payload(crc);
  endfunction

  assign o_ready    = i_ce && (state_q == IDLE || state_q == DATA || state_q == DRAIN);
  assign o_crc_v    = crc_v_q;
  assign o_crc_d    = crc_d_q;
  assign o_crc_en   = crc_en_q;
  assign o_underrun = underrun_q;
  assign o_busy     = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      crc_q      <= 1'b0;
      pad_q      <= 1'b0;
      crc_v_q    <= 1'b0;
      crc_d_q    <= '0;
      crc_en_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (i_ce) begin
        case (state_q)
          IDLE: begin
            crc_v_q <= 1'b0;
            if (i_valid) begin
              crc_q    <= i_cfg_crc;
              pad_q    <= i_cfg_pad;
              crc_en_q <= i_cfg_crc;
              cnt_q    <= LGLEN'(1);
              crc_v_q  <= 1'b1;
              crc_d_q  <= i_data;
              state_q  <= i_last ? after_last(i_cfg_pad, i_cfg_crc, LGLEN'(1)) : DATA;
            end
          end
          DATA: begin
            if (i_valid) begin
              crc_v_q <= 1'b1;
              crc_d_q <= i_data;
              cnt_q   <= sat_inc(cnt_q);
              if (i_last) state_q <= after_last(pad_q, crc_q, sat_inc(cnt_q));
            end else begin
              // Dropping enable with valid makes the appender discard its CRC.
              crc_v_q    <= 1'b0;
              crc_en_q   <= 1'b0;
              underrun_q <= 1'b1;
              state_q    <= DRAIN;
            end
          end
          PAD: begin
            crc_v_q <= 1'b1;
            crc_d_q <= 8'h00;
            cnt_q   <= sat_inc(cnt_q);
            if (sat_inc(cnt_q) >= MIN_L) state_q <= after_payload(crc_q);
          end
          FLUSH: begin
            crc_v_q <= 1'b0;
            if (gap_q == CRC_LAST) begin
              gap_q   <= '0;
              state_q <= IPG;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          DRAIN: begin
            crc_v_q <= 1'b0;
            if (i_valid && i_last) state_q <= IPG;
          end
          IPG: begin
            crc_v_q <= 1'b0;
            if (gap_q == IPG_LAST) begin
              gap_q    <= '0;
              crc_en_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_txcrc_sched.sv
// Scoreboard bench for txcrc_sched: expected {en,data} bytes are queued as beats are
// accepted and compared as the scheduler emits them; gaps and run lengths are checked too.
module tb_txcrc_sched;

  logic       clk = 1'b0;
  logic       i_reset, i_ce, i_cfg_crc, i_cfg_pad, i_valid, i_last;
  logic [7:0] i_data;
  logic       o_ready, o_crc_v, o_crc_en, o_busy, o_underrun;
  logic [7:0] o_crc_d;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  int  run = 0, last_run = 0, ur_cnt = 0;
  bit  hold_on = 0;
  logic       ce_s, prev_v;
  logic [7:0] prev_d;
  int  gap;

  txcrc_sched dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_cfg_crc(i_cfg_crc),
    .i_cfg_pad(i_cfg_pad), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_last(i_last), .o_crc_v(o_crc_v), .o_crc_d(o_crc_d), .o_crc_en(o_crc_en),
    .o_busy(o_busy), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a strobe produced a byte.
  always @(posedge clk) begin
    ce_s = i_ce;
    #1;
    if (!i_reset) begin
      if (o_crc_v) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (ce_s && o_crc_v) begin
        check_eq("sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          check_eq("data", o_crc_d, e[7:0]);
          check_eq("en", o_crc_en, e[8]);
        end
      end
      if (o_underrun) begin
        ur_cnt++;
        check_eq("ur_en", o_crc_en, 0);
        check_eq("ur_v", o_crc_v, 0);
      end
      if (hold_on && !ce_s) begin
        check_eq("hold_d", o_crc_d, prev_d);
        check_eq("hold_v", o_crc_v, prev_v);
      end
      prev_d = o_crc_d;
      prev_v = o_crc_v;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_ce = 1'b1; i_valid = 1'b0; i_last = 1'b0;
    end
  endtask

  // Sends one packet; gap_o counts ready-low strobes before the first beat is taken.
  task automatic send(input int len, input bit crc, input bit pad, input int period,
                      input int ur_at, output int gap_o);
    int i, cyc, budget;
    bit started, ur_done;
    i = 0; cyc = 0; budget = 0; started = 0; ur_done = 0; gap_o = 0;
    while (i < len) begin
      @(negedge clk);
      i_ce      = (cyc % period) == 0;
      cyc++;
      i_cfg_crc = started ? !crc : crc;
      i_cfg_pad = started ? !pad : pad;
      i_valid   = !(started && !ur_done && i == ur_at && i_ce);
      i_data    = 8'hA0 ^ 8'(i);
      i_last    = (i == len - 1);
      #1;
      if (!started && i_ce && !o_ready) gap_o++;
      if (i_valid && o_ready) begin
        if (!ur_done) sb.push_back({crc, i_data});
        started = 1;
        i++;
      end else if (!i_valid && o_ready) begin
        ur_done = 1;
      end
      budget++;
      if (budget > 4000) begin
        check_eq("send_timeout", i, len);
        break;
      end
    end
    if (!ur_done && pad && len < 60)
      for (int k = len; k < 60; k++) sb.push_back({crc, 8'h00});
  endtask

  initial begin
    i_reset = 1'b1; i_ce = 1'b1; i_cfg_crc = 1'b0; i_cfg_pad = 1'b0;
    i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00;
    #12;
    check_eq("rst_v", o_crc_v, 0);
    check_eq("rst_d", o_crc_d, 0);
    check_eq("rst_en", o_crc_en, 0);
    check_eq("rst_ur", o_underrun, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ready", o_ready, 1);
    @(negedge clk);
    i_reset = 1'b0;

    send(64, 1, 1, 1, -1, gap);           // long frame, no padding needed
    check_eq("gap_first", gap, 0);
    send(10, 1, 1, 1, -1, gap);           // short frame padded to 60
    check_eq("gap_flush_ipg", gap, 16);
    check_eq("run64", last_run, 64);
    send(10, 0, 0, 1, -1, gap);           // no pad, no CRC
    check_eq("gap_pad", gap, 66);
    check_eq("run60", last_run, 60);
    hold_on = 1;
    send(20, 1, 1, 3, -1, gap);           // strobe every third clock
    check_eq("gap_nocrc", gap, 12);
    check_eq("run10", last_run, 10);
    ur_cnt = 0;
    send(30, 1, 1, 1, 5, gap);            // underrun after byte 5
    hold_on = 0;
    check_eq("gap_ce3", gap, 56);
    send(8, 1, 0, 1, -1, gap);            // normal frame after underrun
    check_eq("gap_drain", gap, 12);
    check_eq("ur_pulses", ur_cnt, 1);

    send(10, 1, 1, 1, -1, gap);           // async reset while padding
    check_eq("gap_pre_rst", gap, 16);
    idle(5);
    #2;
    i_reset = 1'b1;
    #1;
    check_eq("arst_v", o_crc_v, 0);
    check_eq("arst_en", o_crc_en, 0);
    check_eq("arst_busy", o_busy, 0);
    check_eq("arst_d", o_crc_d, 0);
    sb.delete();
    @(negedge clk);
    i_reset = 1'b0;
    send(10, 1, 1, 1, -1, gap);
    check_eq("gap_post_rst", gap, 0);
    idle(100);
    check_eq("sb_left", sb.size(), 0);
    check_eq("final_busy", o_busy, 0);
    check_eq("ur_total", ur_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/txcrc_sched.md
Name: txcrc_sched

Overview:
- Transmit-side scheduler that sits in front of the byte-wide CRC appender in the Ethernet TX path.
- Accepts a packet byte stream from the TX buffer over a valid/ready handshake and drives the appender's valid, data and enable inputs one byte per i_ce strobe.
- Pads short frames to the Ethernet minimum and reserves the cycles the appender needs to flush its 4-byte CRC.
- Enforces the inter-packet gap, and aborts cleanly (CRC suppressed) on source underrun.

Parameters:
- MIN_LEN, 60: minimum payload bytes before CRC; shorter frames are zero-padded.
- CRC_BYTES, 4: i_ce strobes reserved after the payload for the appender's CRC flush.
- IPG_BYTES, 12: idle i_ce strobes between the end of the CRC and the next frame.
- LGLEN, 11: width of the byte counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset: asynchronous, active-high.
- i_ce  in  1  byte strobe; every state change happens only on a clock with i_ce=1.
- i_cfg_crc  in  1  CRC append enable; latched at frame start.
- i_cfg_pad  in  1  padding enable; latched at frame start.
- i_valid  in  1  source byte valid.
- o_ready  out  1  source byte accepted (combinational).
- i_data  in  8  source byte.
- i_last  in  1  final byte of the packet.
- o_crc_v  out  1  valid to the CRC appender.
- o_crc_d  out  8  data to the CRC appender.
- o_crc_en  out  1  enable to the CRC appender.
- o_busy  out  1  high in any state except IDLE.
- o_underrun  out  1  one-clock pulse when a frame is aborted.

Behaviour:
- Reset (async): state=IDLE, o_crc_v=0, o_crc_d=0, o_crc_en=0, o_underrun=0, counters=0.
- o_ready = i_ce && (state==IDLE || state==DATA || state==DRAIN). A beat is accepted when i_valid && o_ready.
- Registered outputs: an accepted byte appears on o_crc_d with o_crc_v=1 on the next clock.
- o_crc_d and o_crc_v hold their values on clocks without i_ce.

States:
- IDLE:
  - o_crc_v=0.
  - On an accepted beat: latch the cfg bits, set o_crc_en=latched crc, set cnt=1, emit the byte.
  - Then go to DATA, or to the post-last decision if i_last=1.
  - With i_ce and no i_valid: remain in IDLE.
- DATA:
  - Each i_ce with i_valid: emit the byte; cnt increments and saturates at 2^LGLEN-1.
  - Accepted beat with i_last: go to PAD if pad enabled and cnt+1<MIN_LEN; otherwise go to FLUSH.
  - i_ce with !i_valid is an underrun:
    - o_crc_v=0 and o_crc_en=0 on the same clock.
    - Pulse o_underrun.
    - Go to DRAIN.
- PAD: each i_ce emits 0x00 with o_crc_v=1 and increments cnt; after the byte that makes cnt==MIN_LEN, go to FLUSH.
- FLUSH:
  - o_crc_v=0.
  - Wait CRC_BYTES strobes if the latched crc bit is set, otherwise 0 strobes; then go to IPG.
  - o_crc_en holds its value through FLUSH.
- DRAIN:
  - o_crc_v=0 and o_ready follows i_ce; discard input.
  - On an accepted beat with i_last: go to IPG.
  - i_last may already have been consumed. If the underrun occurred after the last beat was accepted, DRAIN is not entered.
- IPG:
  - o_crc_v=0; count IPG_BYTES strobes, then go to IDLE and clear o_crc_en.
  - The next frame's first byte is accepted on the next i_ce in IDLE.
- o_crc_en is stable from the first data byte through the end of FLUSH. This satisfies the appender's stable-enable requirement.
- No frame starts while the appender is flushing. The appender's i_v is never reasserted during its CRC output.
- A mid-frame reset returns everything to IDLE immediately. The partial frame is not resumed.
- cfg inputs changing mid-frame have no effect until the next frame.

Test Plan:
- 64-byte packet, crc=1, pad=1, i_ce always 1 → o_crc_v high for 64 consecutive clocks starting 1 clock after the first accept. Then 4 clocks of FLUSH and 12 of IPG; o_ready low for those 16 clocks.
- 10-byte packet, crc=1, pad=1 → 10 data bytes followed by 50 bytes of 0x00 (60 total with o_crc_v=1), then 4 flush clocks.
- 10-byte packet, pad=0, crc=0 → exactly 10 valid bytes, no flush wait, o_crc_en=0 throughout, IPG of 12.
- i_ce every 3rd clock with a 20-byte packet → all state changes only on strobes, and output bytes are held between strobes.
- i_valid dropped after byte 5 of 30 → o_underrun pulses once, o_crc_en=0 and o_crc_v=0 on the same clock. Remaining 25 bytes are drained, then IPG, then the next frame proceeds normally.
- Async reset asserted in PAD → outputs reach their reset values without waiting for a clock edge. After release, the next packet starts from IDLE with cnt=1.
